// File: rtl/dot_product_reducer.sv
// dot_product_reducer
//   Reduces packed N-lane unsigned product vectors to a single W-bit
//   dot-product sum. The input beat is registered, reduced by a
//   registered binary adder tree (log2(N) stages), then folded into an
//   accumulator. Vectors longer than N lanes arrive as several beats, and
//   in_last marks the final beat of each dot product.
//
//   Optional feature macro: REDUCER_OVF_FLAG_EN
//     defined   -> out_ovf port present; it flags any carry out of W bits in
//                  any tree addition or accumulation behind the result.
//     undefined -> no out_ovf port; all sums wrap silently modulo 2^W.
//
//   Ports
//     clk, rst    rising-edge clock, asynchronous active-high reset
//     in_valid    in_vector/in_last valid
//     in_ready    beat accepted this cycle (combinational from the output side)
//     in_vector   N lanes of W bits; lane i at [W*i +: W]
//     in_last     final beat of the current dot product
//     out_valid   out_sum holds a completed dot product
//     out_ready   sink accepts out_sum this cycle
//     out_sum     dot-product result
//     out_ovf     overflow flag (REDUCER_OVF_FLAG_EN only)
//
//   Timing: a last beat accepted at edge t gives out_valid=1 after edge
//   t+L+1. A single enable (en = !out_valid || out_ready) stalls every
//   stage at once, so beats in flight are never lost or reordered.

// One internal tree node: registered sum of two children.
module dpr_add_node #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef REDUCER_OVF_FLAG_EN
    input  logic         a_ovf,
    input  logic         b_ovf,
    output logic         sum_ovf,
`endif
    output logic [W-1:0] sum
);

`ifdef REDUCER_OVF_FLAG_EN
    logic [W:0] full;
    assign full = {1'b0, a} + {1'b0, b};

    // Overflow is sticky up the tree: a node flags if it carried or if
    // either child already had.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            sum_ovf <= 1'b0;
        end else if (en) begin
            sum     <= full[W-1:0];
            sum_ovf <= full[W] | a_ovf | b_ovf;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= a + b;
        end
    end
`endif

endmodule

module dot_product_reducer #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_vector,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sum
`ifdef REDUCER_OVF_FLAG_EN
    ,
    output logic           out_ovf
`endif
);

    localparam int L = $clog2(N);

    logic en;
    logic accept;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Stage 0: registered input lanes. Stage k (1..L) lives in the tree
    // nodes; vld_pipe[k]/last_pipe[k] describe the data held at stage k.
    logic [N-1:0][W-1:0] lane_q;
    logic [L:0]          vld_pipe;
    logic [L:0]          last_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (en) begin
            if (accept) begin
                lane_q <= in_vector;
            end
            vld_pipe  <= {vld_pipe[L-1:0], accept};
            last_pipe <= {last_pipe[L-1:0], accept & in_last};
        end
    end

    // Heap-indexed tree: node i (1..N-1) sums children 2i and 2i+1, where
    // indices N..2N-1 are the input lanes. Node 1 is the root; the nodes of
    // stage k are N>>k .. (N>>(k-1))-1, so child pairs are lanes (2j, 2j+1)
    // of the previous stage.
    logic [N-1:1][W-1:0] node_sum;
`ifdef REDUCER_OVF_FLAG_EN
    logic [N-1:1]        node_ovf;
`endif

    for (genvar i = 1; i < N; i++) begin : g_node
        logic [W-1:0] a_s;
        logic [W-1:0] b_s;
        logic [W-1:0] s_q;
`ifdef REDUCER_OVF_FLAG_EN
        logic a_o;
        logic b_o;
        logic o_q;
`endif
        if (2 * i >= N) begin : g_leaf_kids
            assign a_s = lane_q[2*i-N];
            assign b_s = lane_q[2*i+1-N];
`ifdef REDUCER_OVF_FLAG_EN
            assign a_o = 1'b0;
            assign b_o = 1'b0;
`endif
        end else begin : g_node_kids
            assign a_s = node_sum[2*i];
            assign b_s = node_sum[2*i+1];
`ifdef REDUCER_OVF_FLAG_EN
            assign a_o = node_ovf[2*i];
            assign b_o = node_ovf[2*i+1];
`endif
        end

        dpr_add_node #(.W(W)) u_node (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .a      (a_s),
            .b      (b_s),
`ifdef REDUCER_OVF_FLAG_EN
            .a_ovf  (a_o),
            .b_ovf  (b_o),
            .sum_ovf(o_q),
`endif
            .sum    (s_q)
        );

        assign node_sum[i] = s_q;
`ifdef REDUCER_OVF_FLAG_EN
        assign node_ovf[i] = o_q;
`endif
    end

    // Accumulator stage.
    logic [W-1:0] acc;
    logic [W-1:0] acc_next;

`ifdef REDUCER_OVF_FLAG_EN
    logic [W:0] acc_full;
    logic       acc_ovf;
    logic       ovf_next;

    assign acc_full = {1'b0, acc} + {1'b0, node_sum[1]};
    assign acc_next = acc_full[W-1:0];
    assign ovf_next = acc_ovf | node_ovf[1] | acc_full[W];
`else
    assign acc_next = acc + node_sum[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
`ifdef REDUCER_OVF_FLAG_EN
            acc_ovf   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else if (en) begin
            // en=1 means any pending result is being consumed (or none is
            // pending), so out_valid simply follows "a last beat completes".
            out_valid <= vld_pipe[L] && last_pipe[L];
            if (vld_pipe[L]) begin
                if (last_pipe[L]) begin
                    out_sum <= acc_next;
                    acc     <= '0;
`ifdef REDUCER_OVF_FLAG_EN
                    out_ovf <= ovf_next;
                    acc_ovf <= 1'b0;
`endif
                end else begin
                    acc     <= acc_next;
`ifdef REDUCER_OVF_FLAG_EN
                    acc_ovf <= ovf_next;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_reducer.sv
module tb_dot_product_reducer;

    localparam int N = 8;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_vector;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
`ifdef REDUCER_OVF_FLAG_EN
    logic           out_ovf;
`endif

    always #5 clk = ~clk;

    dot_product_reducer #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vector(in_vector),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum)
`ifdef REDUCER_OVF_FLAG_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit last_acc;

    // Reference model: exact (64-bit) running dot product; the result is that
    // total mod 2^W, and it overflowed iff the exact total reached 2^W.
    longint unsigned model_acc = 0;
    logic [W-1:0]    exp_sum_q[$];
    bit              exp_ovf_q[$];
    int              con_cyc[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes just before the edge, update the model,
    // then return 1 time unit after the edge.
    task automatic tick();
        longint unsigned s;
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            con_cyc.push_back(cyc);
            if (exp_sum_q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                chk("out_sum", out_sum, exp_sum_q.pop_front());
`ifdef REDUCER_OVF_FLAG_EN
                chk("out_ovf", out_ovf, exp_ovf_q.pop_front());
`else
                exp_ovf_q.delete(0);
`endif
            end
        end
        if (last_acc) begin
            s = 0;
            for (int i = 0; i < N; i++) s += 64'(in_vector[W*i +: W]);
            model_acc += s;
            if (in_last) begin
                exp_sum_q.push_back(model_acc[W-1:0]);
                exp_ovf_q.push_back(model_acc >= (64'd1 << W));
                model_acc = 0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_all(logic [W-1:0] v);
        for (int i = 0; i < N; i++) in_vector[W*i +: W] = v;
    endtask

    task automatic send(bit last, output int tries);
        in_last  = last;
        in_valid = 1'b1;
        tries    = 0;
        do begin
            tick();
            tries++;
        end while (!last_acc && tries < 50);
        chk("send_accept", last_acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_sum_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_sum_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int n;
        int tries;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_vector = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_sum", out_sum, 0);
`ifdef REDUCER_OVF_FLAG_EN
        chk("reset_ovf", out_ovf, 0);
`endif
        rst = 1'b0;
        tick();

        // Lanes 1..8, single beat: sum 36, latency 4, one-cycle pulse.
        for (int i = 0; i < N; i++) in_vector[W*i +: W] = W'(i + 1);
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("t1_accept", last_acc, 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t1_latency", n, 4);
        tick();
        chk("t1_pulse", out_valid, 0);

        // Two-beat product: 8 + 16 = 24, single result.
        con_cyc.delete();
        set_all(1); send(0, tries);
        set_all(2); send(1, tries);
        drain();
        chk("t2_count", con_cyc.size(), 1);

        // Back-to-back single-beat products, no stall on either side.
        con_cyc.delete();
        for (int k = 1; k <= 4; k++) begin
            set_all(W'(k));
            send(1, tries);
            chk("t3_in_ready", tries, 1);
        end
        drain();
        chk("t3_count", con_cyc.size(), 4);
        for (int i = 0; i < 3; i++)
            chk("t3_consec", con_cyc[i+1] - con_cyc[i], 1);

        // Sink back-pressure with beats in flight; input ignored while stalled.
        for (int k = 5; k <= 7; k++) begin
            set_all(W'(k));
            send(1, tries);
        end
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int h = 0; h < 5; h++) begin
            for (int i = 0; i < N; i++) in_vector[W*i +: W] = $urandom;
            tick();
            chk("t4_in_ready", in_ready, 0);
            chk("t4_no_accept", last_acc, 0);
            chk("t4_hold_sum", out_sum, exp_sum_q[0]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        con_cyc.delete();
        drain();
        chk("t4_count", con_cyc.size(), 3);

        // Wrap: 8 * 0xFFFFFFFF -> 0xFFFFFFF8 (overflow), then clean 8.
        set_all('1); send(1, tries);
        set_all(1);  send(1, tries);
        drain();

        // Reset between beats of a 2-beat product discards the partial sum.
        set_all(3); send(0, tries);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_sum", out_sum, 0);
`ifdef REDUCER_OVF_FLAG_EN
        chk("t6_rst_ovf", out_ovf, 0);
`endif
        model_acc = 0;
        exp_sum_q.delete();
        exp_ovf_q.delete();
        tick();
        rst = 1'b0;
        set_all(1); send(1, tries);
        drain();

        // Random beats, gaps and sink stalls.
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom % 4) != 0;
            if (!in_valid && ($urandom % 3) != 0) begin
                for (int i = 0; i < N; i++)
                    in_vector[W*i +: W] = (($urandom % 4) == 0) ? $urandom : ($urandom % 1000);
                in_last  = ($urandom % 3) == 0;
                in_valid = 1'b1;
            end
            tick();
            if (last_acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        n = 0;
        while (in_valid && n < 50) begin
            tick();
            if (last_acc) in_valid = 1'b0;
            n++;
        end
        set_all(7); send(1, tries);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
